// File: rtl/scan_pkg.sv
// Shared definitions for the display scan/decode blocks: mode and state
// encodings plus a one-hot pattern helper.
package scan_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DIRECT = 2'd1;
  localparam logic [1:0] SCAN   = 2'd2;

  localparam int MAX_CH = 64;

  // Callers truncate the result to their own channel count.
  function automatic logic [MAX_CH-1:0] onehot(input int unsigned index,
                                               input logic polarity);
    logic [MAX_CH-1:0] v;
    v = {{(MAX_CH-1){1'b0}}, 1'b1} << index;
    return v ^ {MAX_CH{polarity}};
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: pulses tick on the last cycle of every DIV-cycle period;
// clr holds the count at zero and suppresses the tick.
module tick_gen #(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = ~clr & (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (clr || tick)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/scan_decoder.sv
// Registered binary-to-one-hot decoder with a direct select mode and a
// prescaled round-robin scan mode for multiplexed digit/column drive.
module scan_decoder
  import scan_pkg::*;
#(
  parameter int SEL_W   = 3,
  parameter int NUM_CH  = 8,
  parameter int DIV     = 50000,
  parameter int ACT_LOW = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              mode,
  input  logic [SEL_W-1:0]  sel,
  output logic [NUM_CH-1:0] y,
  output logic [SEL_W-1:0]  idx,
  output logic              wrap
);

  localparam logic              POL      = (ACT_LOW != 0);
  localparam logic [NUM_CH-1:0] INACTIVE = {NUM_CH{POL}};
  localparam logic [SEL_W-1:0]  LAST_IDX = SEL_W'(NUM_CH - 1);
  localparam logic [SEL_W:0]    NUM_CH_W = (SEL_W + 1)'(NUM_CH);

  logic [1:0]        state, nstate;
  logic              clr, tick;
  logic [NUM_CH-1:0] y_d;
  logic [SEL_W-1:0]  idx_d;
  logic              wrap_d;

  // The prescaler only runs while scanning continues across an edge.
  assign clr = !((state == SCAN) && (nstate == SCAN));

  tick_gen #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= nstate;
  end

  always_comb begin
    nstate = IDLE;
    if (en)
      nstate = (mode == MODE_SCAN) ? SCAN : DIRECT;
  end

  // idx doubles as the scan position, so entry and other modes overwrite it.
  always_comb begin
    y_d    = INACTIVE;
    idx_d  = '0;
    wrap_d = 1'b0;
    case (nstate)
      DIRECT: begin
        if ({1'b0, sel} < NUM_CH_W) begin
          idx_d = sel;
          y_d   = NUM_CH'(onehot(32'(sel), POL));
        end
      end
      SCAN: begin
        if (state != SCAN)
          idx_d = '0;
        else if (tick) begin
          wrap_d = (idx == LAST_IDX);
          idx_d  = (idx == LAST_IDX) ? '0 : idx + 1'b1;
        end else
          idx_d = idx;
        y_d = NUM_CH'(onehot(32'(idx_d), POL));
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y    <= INACTIVE;
      idx  <= '0;
      wrap <= 1'b0;
    end else begin
      y    <= y_d;
      idx  <= idx_d;
      wrap <= wrap_d;
    end
  end

endmodule

// File: tb/tb_scan_decoder.sv
// Directed bench for scan_decoder: three instances cover the default
// 8-channel/DIV=4 build, a 5-channel DIV=1 build and an active-low build.
module tb_scan_decoder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       en_a, mode_a;  logic [2:0] sel_a;
  logic [7:0] y_a;           logic [2:0] idx_a;  logic wrap_a;
  logic       en_b, mode_b;  logic [2:0] sel_b;
  logic [4:0] y_b;           logic [2:0] idx_b;  logic wrap_b;
  logic       en_c, mode_c;  logic [2:0] sel_c;
  logic [7:0] y_c;           logic [2:0] idx_c;  logic wrap_c;

  int checks = 0;
  int errors = 0;

  scan_decoder #(.SEL_W(3), .NUM_CH(8), .DIV(4), .ACT_LOW(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .mode(mode_a), .sel(sel_a),
    .y(y_a), .idx(idx_a), .wrap(wrap_a));

  scan_decoder #(.SEL_W(3), .NUM_CH(5), .DIV(1), .ACT_LOW(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .mode(mode_b), .sel(sel_b),
    .y(y_b), .idx(idx_b), .wrap(wrap_b));

  scan_decoder #(.SEL_W(3), .NUM_CH(8), .DIV(4), .ACT_LOW(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .en(en_c), .mode(mode_c), .sel(sel_c),
    .y(y_c), .idx(idx_c), .wrap(wrap_c));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    en_a = 0; mode_a = 0; sel_a = 0;
    en_b = 0; mode_b = 0; sel_b = 0;
    en_c = 0; mode_c = 0; sel_c = 0;
    step(); step();
    chk("rst_y_a", 32'(y_a), 32'h00);
    chk("rst_idx_a", 32'(idx_a), 0);
    chk("rst_wrap_a", 32'(wrap_a), 0);
    chk("rst_y_c", 32'(y_c), 32'hFF);
    rst_n = 1'b1;
    step();
    chk("idle_y_a", 32'(y_a), 32'h00);

    // Direct decode, one-cycle latency
    en_a = 1; mode_a = 0; sel_a = 3'd5;
    step();
    chk("dir5_y", 32'(y_a), 32'h20);
    chk("dir5_idx", 32'(idx_a), 5);
    sel_a = 3'd7;
    #1;
    chk("dir_latency_y", 32'(y_a), 32'h20);
    step();
    chk("dir7_y", 32'(y_a), 32'h80);
    chk("dir7_idx", 32'(idx_a), 7);

    // Scan for 40 cycles, DIV = 4
    mode_a = 1;
    for (int i = 0; i < 40; i++) begin
      step();
      chk($sformatf("scan_y_%0d", i), 32'(y_a), 32'(8'h01 << ((i / 4) % 8)));
      chk($sformatf("scan_idx_%0d", i), 32'(idx_a), (i / 4) % 8);
      chk($sformatf("scan_wrap_%0d", i), 32'(wrap_a), (i == 32) ? 1 : 0);
      chk($sformatf("scan_onehot_%0d", i), 32'($countones(y_a) <= 1), 1);
    end
    repeat (5) step();
    chk("mid_idx3", 32'(idx_a), 3);
    chk("mid_y3", 32'(y_a), 32'h08);

    // Drop enable for two cycles
    en_a = 0;
    step();
    chk("en0_y_1", 32'(y_a), 32'h00);
    chk("en0_idx_1", 32'(idx_a), 0);
    step();
    chk("en0_y_2", 32'(y_a), 32'h00);
    en_a = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("reentry_y_%0d", i), 32'(y_a), 32'h01);
      chk($sformatf("reentry_wrap_%0d", i), 32'(wrap_a), 0);
    end
    step();
    chk("reentry_step_y", 32'(y_a), 32'h02);

    // Scan to idx 6, then switch to direct
    repeat (20) step();
    chk("pre_switch_idx6", 32'(idx_a), 6);
    mode_a = 0; sel_a = 3'd1;
    step();
    chk("switch_dir_y", 32'(y_a), 32'h02);
    chk("switch_dir_idx", 32'(idx_a), 1);
    mode_a = 1;
    step();
    chk("rescan_y", 32'(y_a), 32'h01);
    chk("rescan_idx", 32'(idx_a), 0);
    chk("rescan_wrap", 32'(wrap_a), 0);
    repeat (3) step();
    chk("rescan_hold_y", 32'(y_a), 32'h01);
    step();
    chk("rescan_adv_y", 32'(y_a), 32'h02);
    en_a = 0;

    // NUM_CH = 5, DIV = 1
    en_b = 1; mode_b = 1;
    for (int i = 0; i < 12; i++) begin
      step();
      chk($sformatf("b_idx_%0d", i), 32'(idx_b), i % 5);
      chk($sformatf("b_y_%0d", i), 32'(y_b), 32'(5'b00001 << (i % 5)));
      chk($sformatf("b_wrap_%0d", i), 32'(wrap_b), (i > 0 && i % 5 == 0) ? 1 : 0);
    end
    mode_b = 0; sel_b = 3'd6;
    step();
    chk("b_dir6_y", 32'(y_b), 32'h00);
    chk("b_dir6_idx", 32'(idx_b), 0);
    sel_b = 3'd5;
    step();
    chk("b_dir5_y", 32'(y_b), 32'h00);
    sel_b = 3'd4;
    step();
    chk("b_dir4_y", 32'(y_b), 32'h10);
    chk("b_dir4_idx", 32'(idx_b), 4);
    en_b = 0;

    // Active-low build and asynchronous reset
    en_c = 1; mode_c = 0; sel_c = 3'd2;
    step();
    chk("c_dir2_y", 32'(y_c), 32'hFB);
    chk("c_dir2_idx", 32'(idx_c), 2);
    mode_c = 1;
    step();
    chk("c_scan_y", 32'(y_c), 32'hFE);
    step(); step();
    #3;
    rst_n = 1'b0;
    #1;
    chk("c_async_y", 32'(y_c), 32'hFF);
    chk("c_async_idx", 32'(idx_c), 0);
    chk("c_async_wrap", 32'(wrap_c), 0);
    #2;
    rst_n = 1'b1;
    step();
    chk("c_post_rst_y", 32'(y_c), 32'hFE);
    chk("c_post_rst_idx", 32'(idx_c), 0);
    repeat (4) step();
    chk("c_post_rst_adv", 32'(y_c), 32'hFD);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
